// File: rtl/dotmatrix_scan_ctrl.sv
// Row-scan sequencer for a 16x16 LED dot-matrix driven through 595-style column shift registers.
// Define DOTMATRIX_INVERT_EN to drive inverted column data (common-anode panels, idle sh_dat = 1).
module dotmatrix_scan_ctrl #(
  parameter int CLK_DIV         = 4,
  parameter int DWELL           = 2000,
  parameter int FRAMES_PER_CHAR = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [4:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sh_clk,
  output logic        sh_dat,
  output logic        sh_lat,
  output logic [3:0]  row_sel,
  output logic        row_oe_n,
  output logic        char_idx,
  output logic        frame_done
);

  localparam int CNT_MAX = (DWELL > 2 * CLK_DIV) ? DWELL : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FR_W    = $clog2(FRAMES_PER_CHAR + 1);

`ifdef DOTMATRIX_INVERT_EN
  localparam logic SH_IDLE = 1'b1;
`else
  localparam logic SH_IDLE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_bit;
  logic [14:0]       r_shreg;
  logic [3:0]        r_row;
  logic [FR_W-1:0]   r_frame_cnt;
  logic [4:0]        r_rom_addr;
  logic              r_sh_clk;
  logic              r_sh_dat;
  logic              r_sh_lat;
  logic [3:0]        r_row_sel;
  logic              r_row_oe_n;
  logic              r_char_idx;
  logic              r_frame_done;

  assign rom_addr   = r_rom_addr;
  assign sh_clk     = r_sh_clk;
  assign sh_dat     = r_sh_dat;
  assign sh_lat     = r_sh_lat;
  assign row_sel    = r_row_sel;
  assign row_oe_n   = r_row_oe_n;
  assign char_idx   = r_char_idx;
  assign frame_done = r_frame_done;

  // Scan FSM; each output register holds the value for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= 4'd0;
      r_shreg      <= 15'd0;
      r_row        <= 4'd0;
      r_frame_cnt  <= '0;
      r_rom_addr   <= 5'd0;
      r_sh_clk     <= 1'b0;
      r_sh_dat     <= SH_IDLE;
      r_sh_lat     <= 1'b0;
      r_row_sel    <= 4'd0;
      r_row_oe_n   <= 1'b1;
      r_char_idx   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (!enable) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= 4'd0;
      r_shreg      <= 15'd0;
      r_row        <= 4'd0;
      r_frame_cnt  <= '0;
      r_rom_addr   <= 5'd0;
      r_sh_clk     <= 1'b0;
      r_sh_dat     <= SH_IDLE;
      r_sh_lat     <= 1'b0;
      r_row_sel    <= 4'd0;
      r_row_oe_n   <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          r_rom_addr <= {r_char_idx, r_row};
          r_row_oe_n <= 1'b1;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          r_shreg  <= rom_data[14:0];
          r_sh_dat <= rom_data[15] ^ SH_IDLE;
          r_sh_clk <= 1'b0;
          r_bit    <= 4'd0;
          r_cnt    <= '0;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          // Low half first so data is stable well before the rising edge.
          if (r_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
            r_cnt    <= '0;
            r_sh_clk <= 1'b0;
            if (r_bit == 4'd15) begin
              r_sh_dat  <= SH_IDLE;
              r_sh_lat  <= 1'b1;
              r_row_sel <= r_row;
              r_state   <= S_LATCH;
            end else begin
              r_bit    <= r_bit + 4'd1;
              r_sh_dat <= r_shreg[14] ^ SH_IDLE;
              r_shreg  <= {r_shreg[13:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
              r_sh_clk <= 1'b1;
            end
          end
        end
        S_LATCH: begin
          if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
            r_cnt      <= '0;
            r_sh_lat   <= 1'b0;
            r_row_oe_n <= 1'b0;
            r_state    <= S_DISPLAY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DISPLAY: begin
          if (r_cnt == CNT_W'(DWELL - 1)) begin
            r_cnt      <= '0;
            r_row_oe_n <= 1'b1;
            r_row      <= r_row + 4'd1;
            r_state    <= S_ADDR;
            // Frame end: the toggled char_idx takes effect at the coming ADDR.
            if (r_row == 4'd15) begin
              r_frame_done <= 1'b1;
              if (r_frame_cnt == FR_W'(FRAMES_PER_CHAR - 1)) begin
                r_frame_cnt <= '0;
                r_char_idx  <= ~r_char_idx;
              end else begin
                r_frame_cnt <= r_frame_cnt + FR_W'(1);
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dotmatrix_scan_ctrl.sv
// Directed bench for dotmatrix_scan_ctrl: three instances with different parameter sets
// sharing one combinational glyph ROM model.
module tb_dotmatrix_scan_ctrl;

`ifdef DOTMATRIX_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk;
  logic [15:0] rom [32];

  logic rst_n_a, en_a, rst_n_b, en_b, rst_n_c, en_c;
  logic [4:0] rom_addr_a, rom_addr_b, rom_addr_c;
  logic [15:0] rom_data_a, rom_data_b, rom_data_c;
  logic sh_clk_a, sh_dat_a, sh_lat_a, row_oe_n_a, char_idx_a, frame_done_a;
  logic sh_clk_b, sh_dat_b, sh_lat_b, row_oe_n_b, char_idx_b, frame_done_b;
  logic sh_clk_c, sh_dat_c, sh_lat_c, row_oe_n_c, char_idx_c, frame_done_c;
  logic [3:0] row_sel_a, row_sel_b, row_sel_c;

  int n_checks = 0;
  int n_fail   = 0;

  assign rom_data_a = rom[rom_addr_a];
  assign rom_data_b = rom[rom_addr_b];
  assign rom_data_c = rom[rom_addr_c];

  dotmatrix_scan_ctrl dut_a (
    .clk(clk), .rst_n(rst_n_a), .enable(en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .sh_clk(sh_clk_a), .sh_dat(sh_dat_a), .sh_lat(sh_lat_a), .row_sel(row_sel_a),
    .row_oe_n(row_oe_n_a), .char_idx(char_idx_a), .frame_done(frame_done_a)
  );

  dotmatrix_scan_ctrl #(.CLK_DIV(2), .DWELL(4), .FRAMES_PER_CHAR(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .sh_clk(sh_clk_b), .sh_dat(sh_dat_b), .sh_lat(sh_lat_b), .row_sel(row_sel_b),
    .row_oe_n(row_oe_n_b), .char_idx(char_idx_b), .frame_done(frame_done_b)
  );

  dotmatrix_scan_ctrl #(.CLK_DIV(1), .DWELL(4), .FRAMES_PER_CHAR(2)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .enable(en_c), .rom_addr(rom_addr_c), .rom_data(rom_data_c),
    .sh_clk(sh_clk_c), .sh_dat(sh_dat_c), .sh_lat(sh_lat_c), .row_sel(row_sel_c),
    .row_oe_n(row_oe_n_c), .char_idx(char_idx_c), .frame_done(frame_done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture the 16 bits of one row on dut_b at sh_clk rising edges, then the latch pulse width.
  task automatic cap_b(output logic [15:0] bits, output int nr, output int nl);
    logic prev;
    prev = sh_clk_b;
    bits = 16'd0;
    nr = 0;
    nl = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!prev && sh_clk_b) begin
        bits = {bits[14:0], sh_dat_b};
        nr++;
      end
      prev = sh_clk_b;
      if (nr == 16) break;
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sh_lat_b) nl++;
      else if (nl > 0) break;
    end
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] mask;
    logic [4:0]  e_addr;
    logic        prev, prev_oe, prev_fd;
    int nr, nl, hi, lo, found, rows, pulses, fd_hi;

    for (int i = 0; i < 32; i++) rom[i] = 16'hA5A5 ^ 16'(i * 16'h0111);
    rom[0] = 16'h1000;
    rom[1] = 16'hFFFE;
    mask = {16{INV}};

    rst_n_a = 1'b0; en_a = 1'b0;
    rst_n_b = 1'b0; en_b = 1'b0;
    rst_n_c = 1'b0; en_c = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_rom_addr", rom_addr_a, 5'd0);
    chk("rst_sh_clk", sh_clk_a, 1'b0);
    chk("rst_sh_dat", sh_dat_a, INV);
    chk("rst_sh_lat", sh_lat_a, 1'b0);
    chk("rst_row_sel", row_sel_a, 4'd0);
    chk("rst_row_oe_n", row_oe_n_a, 1'b1);
    chk("rst_char_idx", char_idx_a, 1'b0);
    chk("rst_frame_done", frame_done_a, 1'b0);

    // Default parameters: 2+128+4 = 134 dark cycles, then 2000 lit cycles.
    rst_n_a = 1'b1; en_a = 1'b1;
    hi = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (row_oe_n_a !== 1'b0) hi++;
      else break;
    end
    chk("a_oe_setup", hi, 134);
    chk("a_row_sel0", row_sel_a, 4'd0);
    lo = 1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (row_oe_n_a === 1'b0) lo++;
      else break;
    end
    chk("a_dwell", lo, 2000);
    chk("a_fd_row0", frame_done_a, 1'b0);
    @(negedge clk);
    chk("a_addr_row1", rom_addr_a, 5'd1);
    hi = 2;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (row_oe_n_a !== 1'b0) hi++;
      else break;
    end
    chk("a_oe_gap", hi, 134);
    chk("a_row_sel1", row_sel_a, 4'd1);
    en_a = 1'b0;
    @(negedge clk);
    chk("a_dis_oe", row_oe_n_a, 1'b1);
    chk("a_dis_addr", rom_addr_a, 5'd0);

    // CLK_DIV=2: serial data order and latch width.
    rst_n_b = 1'b1; en_b = 1'b1;
    cap_b(bits, nr, nl);
    chk("b_row0_rises", nr, 16);
    chk("b_row0_bits", bits, 16'h1000 ^ mask);
    chk("b_row0_lat", nl, 2);
    cap_b(bits, nr, nl);
    chk("b_row1_rises", nr, 16);
    chk("b_row1_bits", bits, 16'hFFFE ^ mask);
    chk("b_row1_lat", nl, 2);
    chk("b_row1_oe", row_oe_n_b, 1'b0);
    chk("b_row1_sel", row_sel_b, 4'd1);
    chk("b_disp_sh_dat", sh_dat_b, INV);

    // FRAMES_PER_CHAR=1: char toggles at every frame end.
    found = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (frame_done_b) begin found = 1; break; end
    end
    chk("b_fd_seen", found, 1);
    chk("b_char_toggle", char_idx_b, 1'b1);
    @(negedge clk);
    chk("b_fd_width", frame_done_b, 1'b0);
    chk("b_addr_char1", rom_addr_b, 5'h10);

    // Drop enable during the high half of bit 7.
    nr = 0;
    prev = sh_clk_b;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!prev && sh_clk_b) nr++;
      prev = sh_clk_b;
      if (nr == 8) break;
    end
    chk("b_bit7_reached", nr, 8);
    en_b = 1'b0;
    @(negedge clk);
    chk("b_dis_sh_clk", sh_clk_b, 1'b0);
    chk("b_dis_oe", row_oe_n_b, 1'b1);
    chk("b_dis_sh_lat", sh_lat_b, 1'b0);
    chk("b_dis_sh_dat", sh_dat_b, INV);
    chk("b_dis_char", char_idx_b, 1'b1);
    en_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b_reen_addr", rom_addr_b, 5'h10);

    // Async reset during DISPLAY of row 9.
    found = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (row_oe_n_b === 1'b0 && row_sel_b == 4'd9) begin found = 1; break; end
    end
    chk("b_row9_seen", found, 1);
    #2 rst_n_b = 1'b0;
    #1;
    chk("b_ar_rom_addr", rom_addr_b, 5'd0);
    chk("b_ar_sh_clk", sh_clk_b, 1'b0);
    chk("b_ar_sh_dat", sh_dat_b, INV);
    chk("b_ar_sh_lat", sh_lat_b, 1'b0);
    chk("b_ar_row_sel", row_sel_b, 4'd0);
    chk("b_ar_oe", row_oe_n_b, 1'b1);
    chk("b_ar_char", char_idx_b, 1'b0);
    chk("b_ar_fd", frame_done_b, 1'b0);
    @(negedge clk);
    rst_n_b = 1'b1;
    hi = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (row_oe_n_b !== 1'b0) hi++;
      else break;
    end
    chk("b_restart_setup", hi, 68);
    chk("b_restart_row", row_sel_b, 4'd0);
    chk("b_restart_addr", rom_addr_b, 5'd0);
    en_b = 1'b0;

    // CLK_DIV=1, DWELL=4, FRAMES_PER_CHAR=2: two frames of char 0, then char 1.
    rst_n_c = 1'b1; en_c = 1'b1;
    rows = 0; pulses = 0; fd_hi = 0;
    prev_oe = 1'b1; prev_fd = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (frame_done_c) fd_hi++;
      if (frame_done_c && !prev_fd) pulses++;
      if (prev_oe && !row_oe_n_c) begin
        e_addr[4]   = (rows >= 32);
        e_addr[3:0] = rows[3:0];
        chk("c_row_addr", rom_addr_c, e_addr);
        chk("c_row_char", char_idx_c, e_addr[4]);
        rows++;
      end
      prev_oe = row_oe_n_c;
      prev_fd = frame_done_c;
      if (rows == 48) break;
    end
    chk("c_rows_seen", rows, 48);
    chk("c_fd_pulses", pulses, 2);
    chk("c_fd_cycles", fd_hi, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dotmatrix_scan_ctrl.md
Name: dotmatrix_scan_ctrl

Overview:
Row-scan sequencer for a 16x16 LED dot-matrix panel driven through cascaded serial-in/parallel-out shift registers (595-style).
- Walks the 16-row glyph ROM (5-bit address = {char_idx, row}, 16-bit row word) one row at a time.
- Serialises each row word onto the column shift chain, latches it, then enables that row for a fixed dwell.
- Alternates between the 2 stored characters every FRAMES_PER_CHAR frames.
- Sits between the glyph ROM and the panel connector pins.

Parameters:
CLK_DIV, 4, clk cycles per sh_clk half-period (>=1)
DWELL, 2000, clk cycles a row is lit (>=1)
FRAMES_PER_CHAR, 50, full frames shown before switching character (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  run scanning; low forces IDLE
rom_addr  output  5  glyph ROM address {char_idx, row[3:0]}, registered
rom_data  input  16  glyph ROM row word (combinational ROM, valid 1 cycle after rom_addr changes)
sh_clk  output  1  column shift clock
sh_dat  output  1  column serial data, MSB (bit 15) first
sh_lat  output  1  column storage latch pulse
row_sel  output  4  active row index to row decoder
row_oe_n  output  1  panel output enable, active low
char_idx  output  1  character currently displayed
frame_done  output  1  1-cycle pulse after row 15 dwell completes

Behaviour:
- Reset values (async on rst_n low):
  - rom_addr=0, sh_clk=0, sh_dat=0, sh_lat=0.
  - row_sel=0, row_oe_n=1, char_idx=0, frame_done=0.
  - Row counter=0, frame counter=0, state=IDLE.
- All outputs are registered.
- States:
  - IDLE: outputs at reset values except char_idx/counters held. Goes to ADDR when enable=1.
  - ADDR (1 cycle): rom_addr <= {char_idx, row}; row_oe_n=1.
  - LOAD (1 cycle): shift register <= rom_data; bit counter=0.
  - SHIFT:
    - 16 bits, each bit = 2*CLK_DIV cycles.
    - sh_dat updates at start of the low half; sh_clk rises at start of the high half.
    - After the 16th high half ends, sh_clk returns to 0 and the state goes to LATCH.
  - LATCH: sh_lat=1 for CLK_DIV cycles; row_sel <= row on LATCH entry.
  - DISPLAY:
    - row_oe_n=0 for DWELL cycles.
    - At the end, row_oe_n=1 and row increments (4-bit wrap 15->0).
  - Row wrap:
    - When row 15 finishes DISPLAY, frame_done=1 for exactly 1 cycle (coincident with the return to ADDR) and frame counter increments.
    - When the frame counter reaches FRAMES_PER_CHAR, it clears to 0 and char_idx toggles. The new char_idx applies from the next ADDR.
- Row period: 2 + 32*CLK_DIV + CLK_DIV + DWELL cycles. Default = 2134.
- row_oe_n is high throughout ADDR/LOAD/SHIFT/LATCH (no ghosting).
- Boundary conditions:
  - enable deasserted in any state: next cycle state=IDLE and sh_clk/sh_lat/sh_dat=0, row_oe_n=1. Row and frame counters reset to 0; char_idx is held.
  - Re-enable restarts at row 0 of the current char_idx.
  - rst_n asserted mid-operation: immediate return to reset values, no partial latch pulse completes.
  - FRAMES_PER_CHAR=1: char_idx toggles every frame.
  - Simultaneous row wrap and char toggle on the same cycle is the normal case; frame_done still pulses.

Optional Feature:
DOTMATRIX_INVERT_EN
- Defined: sh_dat carries the inverted row bit (for common-anode panels). Idle/reset level of sh_dat becomes 1.
- Undefined: sh_dat carries the true bit; idle level is 0.
- Timing is identical either way.

Test Plan:
- Default params, enable=1 from reset, probe row_oe_n -> stays 1 through ADDR, LOAD, SHIFT and LATCH; drops to 0 after exactly 2+128+4=134 cycles; stays low for 2000 cycles.
- CLK_DIV=2, rom_data=16'h1000 at row 0 -> sampled sh_dat on 16 sh_clk rising edges = 0,0,0,1,0,...,0; sh_lat high 2 cycles after the 16th falling edge.
- CLK_DIV=1, DWELL=4, FRAMES_PER_CHAR=2 -> rom_addr sequence 0x00..0x0F twice, frame_done pulses twice, then rom_addr 0x10..0x1F with char_idx=1.
- Drop enable mid-SHIFT at bit 7 -> next cycle sh_clk=0, row_oe_n=1, state IDLE; re-enable -> rom_addr={char_idx,4'h0}.
- Assert rst_n=0 during DISPLAY of row 9 -> all outputs at reset values asynchronously; after release, scanning restarts from rom_addr=0x00.
- Build with DOTMATRIX_INVERT_EN, rom_data=16'hFFFE -> sh_dat 0 for the first 15 bits, 1 for the last; idle sh_dat=1.
